fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmit engine that drains the 8-bit synchronous FIFO from its read side. It pulls one byte at a time through the FIFO read handshake and shifts it out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional even parity, then 1 or 2 stop bits. It sits between the FIFO read port and the chip's serial TX pin, and acts as the consumer for whatever logic writes the FIFO.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 to 65535.
- PARITY_EN, 0, 1 inserts an even-parity bit after D7; 0 omits it.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when high, new frames may be started.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO registered read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  one-cycle FIFO read strobe.
- tx  output  1  serial line; idle level is high.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If enable=1 and fifo_empty=0 at an edge, go to FETCH.
- FETCH:
  - Lasts exactly 1 cycle; fifo_rd_en=1 only in this state.
  - Always go to LOAD next.
- LOAD:
  - Lasts 1 cycle.
  - fifo_data is captured into the 8-bit shift register on the exiting edge.
  - Parity is computed as the XOR of the 8 captured bits.
  - Go to START next.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, each CLKS_PER_BIT cycles, LSB first.
  - The shift register shifts right at each bit boundary.
  - A 3-bit bit index counts 0..7.
- PARITY: only when PARITY_EN=1; tx = parity bit for CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 in the final cycle.
  - On the exiting edge, go to FETCH if enable=1 and fifo_empty=0; otherwise go to IDLE.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Cleared on every state entry.
  - The bit boundary occurs when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
- enable is sampled only in IDLE and on the STOP exit. Deasserting it mid-frame never truncates the frame.
- fifo_empty is ignored outside IDLE and the STOP exit. A byte is never requested while fifo_empty=1.
- Exactly one fifo_rd_en pulse per transmitted frame. No read is issued without a subsequent full frame, unless reset intervenes.
- Reset mid-frame:
  - State goes to IDLE on that edge.
  - tx=1, fifo_rd_en=0, busy=0, frame_done=0; counters and shift register are cleared.
  - A byte already read from the FIFO is discarded.

## Timing
- Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0, state IDLE.
- All outputs are registered and change only on a clk edge.
- Start-up latency:
  - Edge E0 sees IDLE with enable=1 and fifo_empty=0.
  - fifo_rd_en is high from E0 to E1.
  - LOAD runs from E1 to E2.
  - tx falls at E2.
- Frame length from tx falling to frame_done deasserting is (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- Back-to-back frames:
  - Inter-frame gap is exactly 2 cycles (FETCH and LOAD) with tx=1, on top of the stop bits.
  - busy stays high across the gap.
- frame_done and fifo_rd_en are each high for exactly 1 cycle per frame.
- frame_done and fifo_rd_en never coincide: FETCH follows STOP.

## Test plan
- Reset and idle:
  - Assert reset for 3 cycles with fifo_empty=0 and enable=1.
  - Required: tx=1, busy=0, fifo_rd_en=0 throughout.
  - Release reset; fifo_rd_en pulses at the first edge after release.
- Single byte 0xA5, CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1:
  - tx bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - frame_done pulses on cycle 40 after tx falls.
  - busy then drops.
- Parity, PARITY_EN=1, byte 0x07:
  - Parity bit 1 appears after D7.
  - Byte 0x03 gives parity bit 0.
  - Frame is 11 bits long.
- Back-to-back bytes 0x55 then 0xFF, STOP_BITS=2:
  - Two fifo_rd_en pulses.
  - Each stop period is 2*CLKS_PER_BIT high, followed by a 2-cycle gap; then start bit of 0xFF.
  - busy never drops between the frames.
- enable dropped mid-DATA of byte 0x3C with the FIFO still non-empty:
  - Frame completes intact.
  - No further fifo_rd_en.
  - Return to IDLE with tx=1.
- reset asserted during the DATA bit 4 of byte 0x81:
  - tx=1 and busy=0 on the next edge.
  - After release, with the FIFO non-empty, a fresh fifo_rd_en and a full new frame follow.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Serial transmit engine draining an 8-bit synchronous FIFO from its read side.
// Each byte is pulled with a one-cycle read strobe, then sent as an async frame:
// start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   PARITY_EN     1 inserts an even-parity bit after D7
//   STOP_BITS     number of stop bits (1 or 2)
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   enable      allows new frames to start (sampled in IDLE and at STOP exit)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle FIFO read strobe (registered)
//   tx          serial line, idle high (registered)
//   busy        high in every state except IDLE (registered)
//   frame_done  one-cycle pulse in the last cycle of the final stop bit (registered)
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            rd_en_q, rd_en_d;
  logic            done_q, done_d;
  logic            at_bound;
  logic            start_ok;

  // Next-state, datapath and next-output computation
  always_comb begin
    at_bound = (cnt_q == CNT_MAX);
    start_ok = enable && !fifo_empty;
    state_d  = state_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (start_ok) state_d = FETCH;
        else          state_d = IDLE;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        // fifo_data is valid now, one cycle after the read strobe
        shreg_d = fifo_data;
        par_d   = ^fifo_data;
        state_d = START;
      end
      START: begin
        if (at_bound) state_d = DATA;
        else          state_d = START;
      end
      DATA: begin
        if (at_bound) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            if (PARITY_EN != 0) state_d = PARITY;
            else                state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (at_bound) state_d = STOP;
        else          state_d = PARITY;
      end
      STOP: begin
        if (at_bound) begin
          if (idx_q == STOP_LAST) begin
            if (start_ok) state_d = FETCH;
            else          state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase

    // Baud and bit counters restart on every state entry
    if (state_d != state_q) begin
      cnt_d = '0;
      idx_d = 3'd0;
    end else if (at_bound || (state_q == IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are derived from the next state so they register in step with it
    rd_en_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (cnt_d == CNT_MAX) && (idx_d == STOP_LAST);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Three transmitter instances (CLKS_PER_BIT=4) share clock, reset and enable:
//   d0: no parity, 1 stop bit; d1: even parity, 1 stop; d2: no parity, 2 stops.
// Each has its own FIFO model. A frame-level reference model tracks the cycle
// offset since each fetch and derives tx/busy/rd/done from the frame layout.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] fifo_empty_s;
  logic [2:0] rd_en_s;
  logic [2:0] tx_s;
  logic [2:0] busy_s;
  logic [2:0] done_s;

  logic [7:0] mem [3][256];
  int         wp [3];
  int         mrp [3];
  int         t [3];
  logic [7:0] cur [3];
  int         nfetch [3];
  int         nrd [3];
  int         n_checks = 0;
  int         n_errors = 0;
  int         pushes = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    int         rp = 0;
    logic [7:0] fdata = 8'h00;
    assign fifo_empty_s[g] = (rp == wp[g]);

    // Registered-read FIFO model
    always @(posedge clk) begin
      if (rd_en_s[g] && !fifo_empty_s[g]) begin
        fdata <= mem[g][rp];
        rp    <= rp + 1;
      end
    end

    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   ((g == 1) ? 1 : 0),
      .STOP_BITS   ((g == 2) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .fifo_empty(fifo_empty_s[g]),
      .fifo_data (fdata),
      .fifo_rd_en(rd_en_s[g]),
      .tx        (tx_s[g]),
      .busy      (busy_s[g]),
      .frame_done(done_s[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  function automatic int nbits(input int i);
    return 9 + ((i == 1) ? 1 : 0) + ((i == 2) ? 2 : 1);
  endfunction

  function automatic logic exp_tx(input int i);
    int k;
    if (t[i] < 2) return 1'b1;
    k = (t[i] - 2) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[i][k-1];
    if ((i == 1) && (k == 9)) return ^cur[i];
    return 1'b1;
  endfunction

  task automatic start_frame(input int i);
    t[i]   = 0;
    cur[i] = mem[i][mrp[i]];
    mrp[i]++;
    nfetch[i]++;
  endtask

  task automatic push(input logic [7:0] b);
    for (int i = 0; i < 3; i++) begin
      mem[i][wp[i]] = b;
      wp[i]++;
    end
    pushes++;
  endtask

  // One clock: advance the model at the rising edge, compare at the falling edge
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        t[i] = -1;
      end else if (t[i] < 0) begin
        if (enable && (mrp[i] != wp[i])) start_frame(i);
      end else begin
        t[i]++;
        if (t[i] == 2 + nbits(i) * CPB) begin
          if (enable && (mrp[i] != wp[i])) start_frame(i);
          else t[i] = -1;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rd_en_s[i] === 1'b1) nrd[i]++;
      check($sformatf("d%0d_tx", i),   {31'd0, tx_s[i]},    {31'd0, exp_tx(i)});
      check($sformatf("d%0d_busy", i), {31'd0, busy_s[i]},  {31'd0, (t[i] >= 0)});
      check($sformatf("d%0d_rd", i),   {31'd0, rd_en_s[i]}, {31'd0, (t[i] == 0)});
      check($sformatf("d%0d_done", i), {31'd0, done_s[i]},
            {31'd0, (t[i] == 1 + nbits(i) * CPB)});
    end
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0; mrp[i] = 0; t[i] = -1; cur[i] = 8'h00; nfetch[i] = 0; nrd[i] = 0;
    end
    reset  = 1'b1;
    enable = 1'b1;
    push(8'hA5);
    @(negedge clk);

    // Reset held with a non-empty FIFO and enable high, then release
    tick_n(3);
    reset = 1'b0;
    tick_n(60);

    // Parity pair 0x07 / 0x03, sent back to back
    push(8'h07);
    push(8'h03);
    tick_n(120);

    // Back-to-back 0x55 then 0xFF
    push(8'h55);
    push(8'hFF);
    tick_n(120);

    // enable dropped mid-DATA of 0x3C while 0x81 waits in the FIFO
    push(8'h3C);
    push(8'h81);
    tick_n(18);
    enable = 1'b0;
    tick_n(80);

    // Reset during data bit 4 of 0x81, then a fresh frame after release
    enable = 1'b1;
    tick_n(24);
    reset = 1'b1;
    tick_n(1);
    push(8'h5A);
    tick_n(1);
    reset = 1'b0;
    tick_n(60);

    // Randomised traffic, enable toggling and occasional resets
    for (int c = 0; c < 900; c++) begin
      if (($urandom_range(0, 47) == 0) && (pushes < 200)) push(8'($urandom));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset  = 1'b0;
    enable = 1'b1;
    tick_n(1500);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d_rd_count", i), nrd[i], nfetch[i]);
      check($sformatf("d%0d_drained", i), {31'd0, fifo_empty_s[i]}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
